// File: rtl/spw_tx_rate_ctrl.sv
// SpaceWire transmit-rate divider control.
// Holds the run-rate divider for the TX clock-enable generator, selects the
// startup rate until the link reaches Run, and accepts host divider writes
// over a valid/ready handshake. Divider changes while running are applied
// only on a bit-enable pulse that lands on a character boundary.
// Optional build macro: SPW_TX_RATE_RAMP_EN -- in RUN, walk the divider one
// step per qualified boundary toward the requested value instead of jumping.
module spw_tx_rate_ctrl #(
  parameter logic [6:0] DEFAULT_DIV = 7'd19,
  parameter logic [6:0] MIN_DIV     = 7'd1
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       link_run,
  input  logic       tx_clk_en,
  input  logic       char_boundary,
  input  logic       cfg_valid,
  input  logic [6:0] cfg_div,
  output logic       cfg_ready,
  output logic [6:0] TX_CLK_DIV,
  output logic       startupRate,
  output logic       rate_update,
  output logic       cfg_err,
  output logic       busy
);

  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [1:0] state_q;
  logic [6:0] div_q;
  logic [6:0] pend_q;
  logic       pend_valid_q;
  logic       rate_update_q;
  logic       err_q;

  logic       qb;
  logic       wr_acc;
  logic       wr_low;
  logic [6:0] wr_div;

  // Qualified boundary, write acceptance and clamped write value
  always_comb begin
    qb     = tx_clk_en & char_boundary;
    wr_acc = cfg_valid & ~pend_valid_q;
    wr_low = (cfg_div < MIN_DIV);
    wr_div = wr_low ? MIN_DIV : cfg_div;
  end

`ifdef SPW_TX_RATE_RAMP_EN
  logic [6:0] step_div;

  // One-step move of the active divider toward the pending target
  always_comb begin
    if (div_q < pend_q)
      step_div = div_q + 7'd1;
    else if (div_q > pend_q)
      step_div = div_q - 7'd1;
    else
      step_div = div_q;
  end
`endif

  // State, divider, pending write and sticky error registers
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q       <= ST_STARTUP;
      div_q         <= DEFAULT_DIV;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      rate_update_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      rate_update_q <= 1'b0;
      if (wr_acc && wr_low)
        err_q <= 1'b1;

      case (state_q)
        ST_STARTUP: begin
          if (wr_acc)
            div_q <= wr_div;
          if (link_run)
            state_q <= ST_ARM;
        end

        ST_ARM: begin
          if (wr_acc)
            div_q <= wr_div;
          if (!link_run)
            state_q <= ST_STARTUP;
          else if (qb)
            state_q <= ST_RUN;
        end

        ST_RUN: begin
          if (!link_run) begin
            // Link drop wins over any boundary: land on the requested value
            // silently. A write accepted in this very cycle goes straight to
            // the divider since no pending stage survives the drop.
            state_q      <= ST_STARTUP;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            if (pend_valid_q)
              div_q <= pend_q;
            else if (wr_acc)
              div_q <= wr_div;
          end else if (pend_valid_q) begin
            if (qb) begin
              rate_update_q <= 1'b1;
`ifdef SPW_TX_RATE_RAMP_EN
              div_q <= step_div;
              if (step_div == pend_q)
                pend_valid_q <= 1'b0;
`else
              div_q        <= pend_q;
              pend_valid_q <= 1'b0;
`endif
            end
          end else if (wr_acc) begin
            pend_q       <= wr_div;
            pend_valid_q <= 1'b1;
          end
        end

        default: state_q <= ST_STARTUP;
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    cfg_ready   = ~pend_valid_q;
    TX_CLK_DIV  = div_q;
    startupRate = (state_q != ST_RUN);
    rate_update = rate_update_q;
    cfg_err     = err_q;
    busy        = pend_valid_q | (state_q == ST_ARM);
  end

endmodule
